// File: rtl/gray_code_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_code_counter
//  Description : Free-running Gray-code counter with registered binary index
//                and wrap pulse; gray_out comes straight from a flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_code_counter #(
    parameter int WIDTH     = 3,
    parameter int COUNT_UP  = 1,
    parameter int RESET_BIN = 0
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] C_RESET_BIN  = RESET_BIN[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_RESET_GRAY = C_RESET_BIN ^ (C_RESET_BIN >> 1);
    localparam logic [WIDTH-1:0] C_ONE        = WIDTH'(1);
    // Index value that the next counting edge carries across the wrap boundary
    localparam logic [WIDTH-1:0] C_WRAP_FROM  = (COUNT_UP != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;

    assign w_bin_next  = (COUNT_UP != 0) ? (r_bin + C_ONE) : (r_bin - C_ONE);
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_bin  <= C_RESET_BIN;
            r_gray <= C_RESET_GRAY;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_wrap <= (r_bin == C_WRAP_FROM);
        end
    end

    assign gray_out = r_gray;
    assign bin_out  = r_bin;
    assign wrap     = r_wrap;

`ifndef SYNTHESIS
    logic             r_chk_seen;
    logic             r_chk_step;
    logic [WIDTH-1:0] r_chk_prev;

    // Checks start only once a reset has given the registers a defined value
    always_ff @(posedge clk) begin
        r_chk_seen <= r_chk_seen | rstn;
        r_chk_step <= r_chk_seen & ~rstn;
        r_chk_prev <= r_gray;
        if (r_chk_step) begin
            assert ($countones(r_gray ^ r_chk_prev) == 1)
                else $error("gray_code_counter: gray step %b -> %b is not one bit", r_chk_prev, r_gray);
        end
        if (r_chk_seen) begin
            assert (r_gray == (r_bin ^ (r_bin >> 1)))
                else $error("gray_code_counter: gray %b does not match bin %b", r_gray, r_bin);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_code_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_code_counter
//  Description : Scoreboard bench for gray_code_counter (up/3, down/3, up/4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_code_counter;

    logic       clk     = 1'b0;
    logic       rstn    = 1'b1;
    logic       rstn_dn = 1'b1;
    logic       rstn_w4 = 1'b1;
    logic [2:0] gray, bin, gray_dn, bin_dn;
    logic [3:0] gray_w4, bin_w4;
    logic       wrap, wrap_dn, wrap_w4;

    always #5 clk = ~clk;

    gray_code_counter #(.WIDTH(3), .COUNT_UP(1), .RESET_BIN(0)) u_dut (
        .clk(clk), .rstn(rstn), .gray_out(gray), .bin_out(bin), .wrap(wrap));

    gray_code_counter #(.WIDTH(3), .COUNT_UP(0), .RESET_BIN(0)) u_dut_dn (
        .clk(clk), .rstn(rstn_dn), .gray_out(gray_dn), .bin_out(bin_dn), .wrap(wrap_dn));

    gray_code_counter #(.WIDTH(4), .COUNT_UP(1), .RESET_BIN(5)) u_dut_w4 (
        .clk(clk), .rstn(rstn_w4), .gray_out(gray_w4), .bin_out(bin_w4), .wrap(wrap_w4));

    typedef struct packed {
        logic [3:0] gray;
        logic [3:0] bin;
        logic       wrap;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push_exp(input logic [3:0] g, input logic [3:0] b, input logic w);
        exp_t e;
        e.gray = g;
        e.bin  = b;
        e.wrap = w;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_exp(4'b0000, 4'd0, 1'b0);
            tick();
            e = sbq.pop_front();
            n_tests++;
            if ({1'b0, gray} !== e.gray || {1'b0, bin} !== e.bin || wrap !== e.wrap) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got gray=%b bin=%b wrap=%b, want gray=%b bin=%b wrap=%b",
                         i, gray, bin, wrap, e.gray[2:0], e.bin[2:0], e.wrap);
            end
        end
    endtask

    task automatic test_sequence_up();
        exp_t       e;
        logic [2:0] up_g [8];
        up_g = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        rstn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_exp({1'b0, up_g[i]}, 4'((i + 1) % 8), (i == 7));
            tick();
            e = sbq.pop_front();
            n_tests++;
            if ({1'b0, gray} !== e.gray || {1'b0, bin} !== e.bin || wrap !== e.wrap) begin
                n_fail++;
                $display("FAIL seq_up[%0d]: got gray=%b bin=%b wrap=%b, want gray=%b bin=%b wrap=%b",
                         i, gray, bin, wrap, e.gray[2:0], e.bin[2:0], e.wrap);
            end
        end
    endtask

    task automatic test_gray_property();
        exp_t       e;
        logic [2:0] prev;
        logic [2:0] mb;
        int         m_bin = 0;
        for (int i = 0; i < 20; i++) begin
            prev  = gray;
            m_bin = (m_bin + 1) % 8;
            mb    = 3'(m_bin);
            push_exp({1'b0, mb ^ (mb >> 1)}, {1'b0, mb}, (m_bin == 0));
            tick();
            e = sbq.pop_front();
            n_tests++;
            if ({1'b0, gray} !== e.gray || {1'b0, bin} !== e.bin || wrap !== e.wrap ||
                $countones(gray ^ prev) != 1 || gray !== (bin ^ (bin >> 1))) begin
                n_fail++;
                $display("FAIL gray_prop[%0d]: got prev=%b gray=%b bin=%b wrap=%b, want gray=%b bin=%b wrap=%b one-bit step",
                         i, prev, gray, bin, wrap, e.gray[2:0], e.bin[2:0], e.wrap);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        exp_t e;
        // 28 counting edges from index 0 leave the counter at index 4 (gray 110)
        n_tests++;
        if (gray !== 3'b110) begin
            n_fail++;
            $display("FAIL mid_reset_pre: got gray=%b, want gray=110", gray);
        end
        rstn = 1'b1;
        push_exp(4'b0000, 4'd0, 1'b0);
        tick();
        e = sbq.pop_front();
        n_tests++;
        if ({1'b0, gray} !== e.gray || {1'b0, bin} !== e.bin || wrap !== e.wrap) begin
            n_fail++;
            $display("FAIL mid_reset: got gray=%b bin=%b wrap=%b, want gray=%b bin=%b wrap=%b",
                     gray, bin, wrap, e.gray[2:0], e.bin[2:0], e.wrap);
        end
        rstn = 1'b0;
        push_exp(4'b0001, 4'd1, 1'b0);
        push_exp(4'b0011, 4'd2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sbq.pop_front();
            n_tests++;
            if ({1'b0, gray} !== e.gray || {1'b0, bin} !== e.bin || wrap !== e.wrap) begin
                n_fail++;
                $display("FAIL mid_resume[%0d]: got gray=%b bin=%b wrap=%b, want gray=%b bin=%b wrap=%b",
                         i, gray, bin, wrap, e.gray[2:0], e.bin[2:0], e.wrap);
            end
        end
    endtask

    task automatic test_count_down();
        exp_t       e;
        logic [2:0] dn_g [9];
        logic [2:0] dn_b [9];
        dn_g = '{3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000, 3'b100};
        dn_b = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        rstn_dn = 1'b1;
        push_exp(4'b0000, 4'd0, 1'b0);
        tick();
        e = sbq.pop_front();
        n_tests++;
        if ({1'b0, gray_dn} !== e.gray || {1'b0, bin_dn} !== e.bin || wrap_dn !== e.wrap) begin
            n_fail++;
            $display("FAIL down_reset: got gray=%b bin=%b wrap=%b, want gray=%b bin=%b wrap=%b",
                     gray_dn, bin_dn, wrap_dn, e.gray[2:0], e.bin[2:0], e.wrap);
        end
        rstn_dn = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push_exp({1'b0, dn_g[i]}, {1'b0, dn_b[i]}, (i == 0 || i == 8));
            tick();
            e = sbq.pop_front();
            n_tests++;
            if ({1'b0, gray_dn} !== e.gray || {1'b0, bin_dn} !== e.bin || wrap_dn !== e.wrap) begin
                n_fail++;
                $display("FAIL down_seq[%0d]: got gray=%b bin=%b wrap=%b, want gray=%b bin=%b wrap=%b",
                         i, gray_dn, bin_dn, wrap_dn, e.gray[2:0], e.bin[2:0], e.wrap);
            end
        end
    endtask

    task automatic test_width4_reset_bin();
        exp_t       e;
        logic [3:0] w4_g [12];
        w4_g = '{4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000, 4'b0001};
        rstn_w4 = 1'b1;
        push_exp(4'b0111, 4'd5, 1'b0);
        tick();
        e = sbq.pop_front();
        n_tests++;
        if (gray_w4 !== e.gray || bin_w4 !== e.bin || wrap_w4 !== e.wrap) begin
            n_fail++;
            $display("FAIL w4_reset: got gray=%b bin=%0d wrap=%b, want gray=%b bin=%0d wrap=%b",
                     gray_w4, bin_w4, wrap_w4, e.gray, e.bin, e.wrap);
        end
        rstn_w4 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            push_exp(w4_g[i], 4'((i + 6) % 16), (i == 10));
            tick();
            e = sbq.pop_front();
            n_tests++;
            if (gray_w4 !== e.gray || bin_w4 !== e.bin || wrap_w4 !== e.wrap) begin
                n_fail++;
                $display("FAIL w4_seq[%0d]: got gray=%b bin=%0d wrap=%b, want gray=%b bin=%0d wrap=%b",
                         i, gray_w4, bin_w4, wrap_w4, e.gray, e.bin, e.wrap);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequence_up();
        test_gray_property();
        test_reset_mid_count();
        test_count_down();
        test_width4_reset_bin();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
